// File: rtl/int_ctrl_pkg.sv
// Shared types and helpers for the vectored interrupt controller.
// Optional periodic timer source is enabled with INT_TIMER_EN.
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    localparam int ID_W = 4;

    function automatic logic [31:0] vec_of(
        input logic [ID_W-1:0] ch,
        input int              base,
        input int              stride
    );
        return 32'(base + int'(ch) * stride);
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder over the enabled pending sources.
// Reports whether any source is active and which one wins.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    always_comb begin
        valid = |req;
        id    = '0;
        // Walk downward so the lowest set index is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) id = ID_W'(i);
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Vectored interrupt controller: edge latch, mask, fixed priority, req/ack/end.
// Define INT_TIMER_EN to add a periodic timer as lowest-priority source N_CH.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int PC_W       = 10,
    parameter int VEC_BASE   = 1,
    parameter int VEC_STRIDE = 1,
    parameter int TMR_W      = 16,
`ifdef INT_TIMER_EN
    localparam int NSRC = N_CH + 1
`else
    localparam int NSRC = N_CH
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  irq_in,
    input  logic             mask_we,
    input  logic [NSRC-1:0]  mask_d,
    output logic [NSRC-1:0]  mask_q,
    output logic [NSRC-1:0]  pend_q,
    output logic             int_req,
    output logic [PC_W-1:0]  int_vec,
    output logic [ID_W-1:0]  int_id,
    input  logic             int_ack,
    input  logic             int_end,
    output logic             busy
`ifdef INT_TIMER_EN
    ,
    input  logic             tmr_we,
    input  logic [TMR_W-1:0] tmr_period_d
`endif
);

    if (N_CH < 1 || N_CH > 16 || PC_W < 1 || TMR_W < 1 ||
        NSRC > (1 << ID_W)) begin : g_cfg_err
        $error("int_ctrl: unsupported parameter set");
    end

    state_t          state;
    logic [N_CH-1:0] prev_irq;
    logic [NSRC-1:0] set_bits;
    logic [NSRC-1:0] clr_bits;
    logic [NSRC-1:0] active;
    logic            win_valid;
    logic [ID_W-1:0] win_id;
    logic            tmr_hit;

    assign active = pend_q & mask_q;

    int_prio_enc #(
        .N(NSRC)
    ) u_enc (
        .req  (active),
        .valid(win_valid),
        .id   (win_id)
    );

`ifdef INT_TIMER_EN
    logic [TMR_W-1:0] tmr_count;
    logic [TMR_W-1:0] tmr_period;

    assign tmr_hit = !tmr_we && (tmr_period != '0) &&
                     (tmr_count == tmr_period - 1'b1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tmr_count  <= '0;
            tmr_period <= '0;
        end else if (tmr_we) begin
            tmr_period <= tmr_period_d;
            tmr_count  <= '0;
        end else if (tmr_period != '0) begin
            if (tmr_hit) tmr_count <= '0;
            else         tmr_count <= tmr_count + 1'b1;
        end
    end
`else
    assign tmr_hit = 1'b0;
`endif

    always_comb begin
        set_bits            = '0;
        set_bits[N_CH-1:0]  = irq_in & ~prev_irq;
`ifdef INT_TIMER_EN
        set_bits[N_CH]      = tmr_hit;
`endif
    end

    // Only the granted source is consumed, and only when the ack lands in REQ.
    always_comb begin
        clr_bits = '0;
        for (int i = 0; i < NSRC; i++) begin
            clr_bits[i] = (state == REQ) && int_ack && (int_id == ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            prev_irq <= '0;
            mask_q   <= '0;
            pend_q   <= '0;
            int_req  <= 1'b0;
            int_vec  <= '0;
            int_id   <= '0;
            busy     <= 1'b0;
        end else begin
            prev_irq <= irq_in;
            if (mask_we) mask_q <= mask_d;
            // A fresh edge on the acked source wins over its clear.
            pend_q <= (pend_q & ~clr_bits) | set_bits;
            unique case (state)
                IDLE: begin
                    if (win_valid) begin
                        state   <= REQ;
                        int_req <= 1'b1;
                        int_id  <= win_id;
                        int_vec <= PC_W'(vec_of(win_id, VEC_BASE, VEC_STRIDE));
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state   <= SERVICE;
                        int_req <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (int_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    localparam int N_CH       = 4;
    localparam int PC_W       = 10;
    localparam int VEC_BASE   = 1;
    localparam int VEC_STRIDE = 1;
    localparam int TMR_W      = 16;
`ifdef INT_TIMER_EN
    localparam int NSRC = N_CH + 1;
`else
    localparam int NSRC = N_CH;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [N_CH-1:0]  irq_in;
    logic             mask_we;
    logic [NSRC-1:0]  mask_d;
    logic [NSRC-1:0]  mask_q;
    logic [NSRC-1:0]  pend_q;
    logic             int_req;
    logic [PC_W-1:0]  int_vec;
    logic [ID_W-1:0]  int_id;
    logic             int_ack;
    logic             int_end;
    logic             busy;
    logic             tmr_we;
    logic [TMR_W-1:0] tmr_period_d;

    int total = 0;
    int bad   = 0;

    int_ctrl #(
        .N_CH      (N_CH),
        .PC_W      (PC_W),
        .VEC_BASE  (VEC_BASE),
        .VEC_STRIDE(VEC_STRIDE),
        .TMR_W     (TMR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_in      (irq_in),
        .mask_we     (mask_we),
        .mask_d      (mask_d),
        .mask_q      (mask_q),
        .pend_q      (pend_q),
        .int_req     (int_req),
        .int_vec     (int_vec),
        .int_id      (int_id),
        .int_ack     (int_ack),
        .int_end     (int_end),
        .busy        (busy)
`ifdef INT_TIMER_EN
        ,
        .tmr_we      (tmr_we),
        .tmr_period_d(tmr_period_d)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a grant is a channel number (-1 = none), plus a
    // flag saying whether the CPU has taken it and is still servicing it.
    logic [NSRC-1:0] m_pend, m_mask, m_nxt, m_set;
    logic [N_CH-1:0] m_prev;
    logic [PC_W-1:0] m_vec;
    int              m_id, m_gnt, m_cnt, m_per;
    bit              m_srv;

    always @(posedge clk) begin
        if (!reset) begin
            m_pend = '0; m_mask = '0; m_prev = '0;
            m_gnt = -1; m_srv = 0; m_vec = '0; m_id = 0;
            m_cnt = 0; m_per = 0;
        end else begin
            m_set = '0;
            m_set[N_CH-1:0] = irq_in & ~m_prev;
            m_nxt = m_pend;
            if (m_srv) begin
                if (int_end) begin m_srv = 0; m_gnt = -1; end
            end else if (m_gnt >= 0) begin
                if (int_ack) begin m_nxt[m_gnt] = 1'b0; m_srv = 1; end
            end else begin
                for (int i = NSRC - 1; i >= 0; i--)
                    if (m_pend[i] && m_mask[i]) m_gnt = i;
                if (m_gnt >= 0) begin
                    m_id  = m_gnt;
                    m_vec = PC_W'(VEC_BASE + m_gnt * VEC_STRIDE);
                end
            end
`ifdef INT_TIMER_EN
            if (tmr_we) begin
                m_per = int'(tmr_period_d); m_cnt = 0;
            end else if (m_per != 0) begin
                if (m_cnt == m_per - 1) begin m_cnt = 0; m_set[N_CH] = 1'b1; end
                else m_cnt++;
            end
`endif
            m_pend = m_nxt | m_set;
            m_prev = irq_in;
            if (mask_we) m_mask = mask_d;
        end
    end

    always @(posedge clk) begin
        #2;
        chk("int_req", 32'(int_req), 32'(m_gnt >= 0 && !m_srv));
        chk("busy", 32'(busy), 32'(m_srv));
        chk("pend_q", 32'(pend_q), 32'(m_pend));
        chk("mask_q", 32'(mask_q), 32'(m_mask));
        if (m_gnt >= 0 && !m_srv) begin
            chk("int_vec", 32'(int_vec), 32'(m_vec));
            chk("int_id", 32'(int_id), 32'(m_id));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_mask(input logic [NSRC-1:0] m);
        mask_we = 1'b1; mask_d = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic serve();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0; int_end = 1'b1;
        tick();
        int_end = 1'b0;
    endtask

    initial begin
        reset = 1'b0; irq_in = '0; mask_we = 1'b0; mask_d = '0;
        int_ack = 1'b0; int_end = 1'b0; tmr_we = 1'b0; tmr_period_d = '0;
        tick(); tick();
        chk("rst_req", 32'(int_req), 0);
        chk("rst_vec", 32'(int_vec), 0);
        chk("rst_id", 32'(int_id), 0);
        chk("rst_pend", 32'(pend_q), 0);
        reset = 1'b1;

        // 1: single edge on ch2
        set_mask('1);
        irq_in[2] = 1'b1;
        tick();
        irq_in = '0;
        chk("t1_pend", 32'(pend_q), 32'h4);
        chk("t1_req_early", 32'(int_req), 0);
        tick();
        chk("t1_req", 32'(int_req), 1);
        chk("t1_vec", 32'(int_vec), 3);
        chk("t1_id", 32'(int_id), 2);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("t1_busy1", 32'(busy), 1);
        chk("t1_pend_clr", 32'(pend_q), 0);
        int_end = 1'b1;
        tick();
        int_end = 1'b0;
        chk("t1_busy0", 32'(busy), 0);

        // 2: ch1 and ch3 together, ch1 first
        irq_in = 4'b1010;
        tick();
        irq_in = '0;
        tick();
        chk("t2_vec_a", 32'(int_vec), 2);
        serve();
        chk("t2_gap", 32'(int_req), 0);
        tick();
        chk("t2_req_b", 32'(int_req), 1);
        chk("t2_vec_b", 32'(int_vec), 4);
        serve();

        // 3: masked pending held until unmasked
        set_mask('0);
        irq_in[0] = 1'b1;
        tick();
        irq_in = '0;
        tick();
        chk("t3_noreq", 32'(int_req), 0);
        chk("t3_pend", 32'(pend_q), 1);
        set_mask(NSRC'(1));
        chk("t3_req_early", 32'(int_req), 0);
        tick();
        chk("t3_req", 32'(int_req), 1);
        chk("t3_vec", 32'(int_vec), 1);
        serve();
        set_mask('1);

        // 4: new edge coincident with its own ack
        irq_in[2] = 1'b1;
        tick();
        irq_in = '0;
        tick();
        chk("t4_id", 32'(int_id), 2);
        int_ack = 1'b1; irq_in[2] = 1'b1;
        tick();
        int_ack = 1'b0; irq_in = '0;
        chk("t4_pend_kept", 32'(pend_q[2]), 1);
        int_end = 1'b1;
        tick();
        int_end = 1'b0;
        tick();
        chk("t4_rereq", 32'(int_req), 1);
        chk("t4_reid", 32'(int_id), 2);
        serve();

        // 5: reset while in service
        irq_in[1] = 1'b1;
        tick();
        irq_in = '0;
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("t5_busy", 32'(busy), 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t5_req", 32'(int_req), 0);
        chk("t5_busy0", 32'(busy), 0);
        chk("t5_pend", 32'(pend_q), 0);
        chk("t5_mask", 32'(mask_q), 0);

`ifdef INT_TIMER_EN
        // 6: timer period 5 as source N_CH
        set_mask(NSRC'(1) << N_CH);
        tmr_we = 1'b1; tmr_period_d = 16'd5;
        tick();
        tmr_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_pend_lo", 32'(pend_q[N_CH]), 0);
        end
        tick();
        chk("t6_pend_hi", 32'(pend_q[N_CH]), 1);
        tick();
        chk("t6_req", 32'(int_req), 1);
        chk("t6_vec", 32'(int_vec), 5);
        tmr_we = 1'b1; tmr_period_d = '0;
        tick();
        tmr_we = 1'b0;
        serve();
`endif

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom_range(0, 299) != 0);
            irq_in  = N_CH'($urandom) & N_CH'($urandom);
            mask_we = ($urandom_range(0, 15) == 0);
            mask_d  = NSRC'($urandom) | NSRC'($urandom);
            int_ack = ($urandom_range(0, 2) == 0);
            int_end = ($urandom_range(0, 3) == 0);
            tmr_we  = ($urandom_range(0, 99) == 0);
            tmr_period_d = TMR_W'($urandom_range(0, 7));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
